pwr_cntr_bank: RTL

PWR_CNTR_BANK -- requirements
Module: pwr_cntr_bank

---
 rtl/pwr_pkg.sv | 15 +
 rtl/pwr_sat_add.sv | 19 +
 rtl/pwr_cntr_bank.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/pwr_pkg.sv
// Shared constants and FSM state type for the power-counter bank.
package pwr_pkg;

  localparam int unsigned PWR_N_CNTR = 8;
  localparam int unsigned PWR_CNT_W  = 16;
  localparam int unsigned PWR_W_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_PRESENT = 2'd2,
    ST_DONE    = 2'd3
  } pwr_state_e;

endpackage

// File: rtl/pwr_sat_add.sv
// Saturating accumulator adder: CNT_W accumulator plus a W_W weight.
// sat_o flags that the true sum did not fit and was clamped to all-ones.
module pwr_sat_add #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned W_W   = 4
) (
  input  logic [CNT_W-1:0] acc_i,
  input  logic [W_W-1:0]   add_i,
  output logic [CNT_W-1:0] sum_o,
  output logic             sat_o
);

  logic [CNT_W:0] wide_s;

  assign wide_s = {1'b0, acc_i} + (CNT_W+1)'(add_i);
  assign sat_o  = wide_s[CNT_W];
  assign sum_o  = sat_o ? {CNT_W{1'b1}} : wide_s[CNT_W-1:0];

endmodule

// File: rtl/pwr_cntr_bank.sv
// Bank of saturating power counters fed by weighted toggle events, with a
// ready/valid readout scan that can clear each counter as it is read.
module pwr_cntr_bank
  import pwr_pkg::*;
#(
  parameter int unsigned N_CNTR      = PWR_N_CNTR,
  parameter int unsigned CNT_W       = PWR_CNT_W,
  parameter int unsigned W_W         = PWR_W_W,
  parameter int unsigned CLR_ON_READ = 1,
  localparam int unsigned IDX_W      = (N_CNTR > 1) ? $clog2(N_CNTR) : 1
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             ev_valid,
  input  logic [IDX_W-1:0] ev_idx,
  input  logic [W_W-1:0]   ev_weight,
  input  logic             start,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [IDX_W-1:0] rd_idx,
  output logic [CNT_W-1:0] rd_data,
  output logic             rd_last,
  output logic             busy,
  output logic             ovf
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CNTR - 1);

  pwr_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             rd_last_q, rd_last_d;
  logic             busy_q, busy_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q [N_CNTR];

  logic             ev_hit_s;
  logic [IDX_W-1:0] ev_sel_s;
  logic [CNT_W-1:0] acc_s;
  logic [CNT_W-1:0] sum_s;
  logic             sat_s;
  logic             accept_s;
  logic             clr_s;
  logic             sat_eff_s;

  assign ev_hit_s = ev_valid && ({1'b0, ev_idx} < (IDX_W+1)'(N_CNTR));
  assign ev_sel_s = ev_hit_s ? ev_idx : {IDX_W{1'b0}};
  assign acc_s    = cnt_q[ev_sel_s];
  assign accept_s = (state_q == ST_PRESENT) && rd_ready;
  assign clr_s    = accept_s && (CLR_ON_READ != 0);
  // A clear-on-read of the event's own counter replaces the sum, so no saturation occurs.
  assign sat_eff_s = ev_hit_s && sat_s && !(clr_s && (ev_sel_s == idx_q));

  pwr_sat_add #(
    .CNT_W (CNT_W),
    .W_W   (W_W)
  ) u_sat_add (
    .acc_i (acc_s),
    .add_i (ev_weight),
    .sum_o (sum_s),
    .sat_o (sat_s)
  );

  // Counter array: event accumulation, clear-on-read keeps a same-cycle event.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int i = 0; i < N_CNTR; i++) begin
        cnt_q[i] <= {CNT_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < N_CNTR; i++) begin
        if (clr_s && (idx_q == IDX_W'(i))) begin
          cnt_q[i] <= (ev_hit_s && (ev_sel_s == IDX_W'(i))) ? CNT_W'(ev_weight) : {CNT_W{1'b0}};
        end else if (ev_hit_s && (ev_sel_s == IDX_W'(i))) begin
          cnt_q[i] <= sum_s;
        end
      end
    end
  end

  // Scan FSM state and registered readout outputs.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q    <= ST_IDLE;
      idx_q      <= {IDX_W{1'b0}};
      rd_data_q  <= {CNT_W{1'b0}};
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      busy_q     <= busy_d;
      ovf_q      <= ovf_d;
    end
  end

  // Next-state and next-output decode for the readout scan.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    rd_last_d  = rd_last_q;
    busy_d     = busy_q;
    ovf_d      = ovf_q | sat_eff_s;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          idx_d   = {IDX_W{1'b0}};
          busy_d  = 1'b1;
          ovf_d   = sat_eff_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // Capture the pre-event value; a same-cycle event stays in the counter.
        rd_data_d  = cnt_q[idx_q];
        rd_last_d  = (idx_q == LAST_IDX);
        rd_valid_d = 1'b1;
        state_d    = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (rd_ready) begin
          rd_valid_d = 1'b0;
          rd_last_d  = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_PRESENT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        idx_d   = {IDX_W{1'b0}};
      end
      default: begin
        state_d    = ST_IDLE;
        rd_valid_d = 1'b0;
        rd_last_d  = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  assign rd_valid = rd_valid_q;
  assign rd_idx   = idx_q;
  assign rd_data  = rd_data_q;
  assign rd_last  = rd_last_q;
  assign busy     = busy_q;
  assign ovf      = ovf_q;

endmodule
